gpio_bank: RTL and testbench

- Parametrised GPIO bank on the J1 I/O bus. Successor to the fixed 8-bit port-plus-direction-register pair.
- Adds atomic set/clear/toggle writes, multi-stage input synchronisation, per-bit rising/falling edge capture with write-1-to-clear status, and a level interrupt output.
- One instance per header/PMOD group. The top level decodes its one-hot I/O address bit into `cs` and wires `pin_out`/`pin_oe`/`pin_in` to SB_IO primitives.

---
 rtl/gpio_bank_if.sv | 13 +
 rtl/gpio_bank.sv | 148 ++++++++++++++
 tb/tb_gpio_bank.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_if.sv
// J1 I/O bus slice seen by one GPIO bank: decoded select, register index,
// read/write strobes and the 16-bit data paths.
interface gpio_bank_if;
    logic        cs;
    logic [3:0]  addr;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] wd;
    logic [15:0] rd;

    modport master (output cs, output addr, output io_wr, output io_rd, output wd, input rd);
    modport slave  (input cs, input addr, input io_wr, input io_rd, input wd, output rd);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: OUT/DIR with atomic set/clear/toggle, synchronised
// inputs, per-bit edge capture into W1C event flags and a level interrupt.
module gpio_bank #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] DIR_RESET   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam logic [3:0] A_OUT  = 4'd0;
    localparam logic [3:0] A_DIR  = 4'd1;
    localparam logic [3:0] A_SET  = 4'd2;
    localparam logic [3:0] A_CLR  = 4'd3;
    localparam logic [3:0] A_TGL  = 4'd4;
    localparam logic [3:0] A_IN   = 4'd5;
    localparam logic [3:0] A_EVT  = 4'd6;
    localparam logic [3:0] A_IEN  = 4'd7;
    localparam logic [3:0] A_RISE = 4'd8;
    localparam logic [3:0] A_FALL = 4'd9;
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    function automatic logic [15:0] zext(input logic [WIDTH-1:0] v);
        logic [15:0] r;
        r = 16'h0000;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] out_r, dir_r, ien_r, rise_en_r, fall_en_r, evt_r, prev_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [2:0]       prime_cnt_r;
    logic             primed_r;
    logic [15:0]      rd_r;
    logic             irq_r;

    logic             wr_sel_s, rd_sel_s, unused_wd_s;
    logic [WIDTH-1:0] wdw_s, in_s, evt_set_s, evt_clr_s;
    logic [15:0]      rd_mux_s;

    assign wr_sel_s    = bus.cs & bus.io_wr;
    assign rd_sel_s    = bus.cs & bus.io_rd;
    assign wdw_s       = bus.wd[WIDTH-1:0];
    assign unused_wd_s = ^bus.wd;
    assign in_s        = sync_r[SYNC_STAGES-1];

    assign pin_out = out_r;
    assign pin_oe  = dir_r;
    assign irq     = irq_r;
    assign bus.rd  = rd_r;

    // Edge events are masked until the synchroniser has flushed its reset zeros.
    always_comb begin
        evt_set_s = {WIDTH{1'b0}};
        if (primed_r) begin
            evt_set_s = (in_s & ~prev_r & rise_en_r) | (~in_s & prev_r & fall_en_r);
        end else begin
            evt_set_s = {WIDTH{1'b0}};
        end
    end

    // W1C mask for the event register
    always_comb begin
        evt_clr_s = {WIDTH{1'b0}};
        if (wr_sel_s && (bus.addr == A_EVT)) begin
            evt_clr_s = wdw_s;
        end else begin
            evt_clr_s = {WIDTH{1'b0}};
        end
    end

    // Read-data multiplexer
    always_comb begin
        rd_mux_s = 16'h0000;
        case (bus.addr)
            A_OUT, A_SET, A_CLR, A_TGL: rd_mux_s = zext(out_r);
            A_DIR:  rd_mux_s = zext(dir_r);
            A_IN:   rd_mux_s = zext(in_s);
            A_EVT:  rd_mux_s = zext(evt_r);
            A_IEN:  rd_mux_s = zext(ien_r);
            A_RISE: rd_mux_s = zext(rise_en_r);
            A_FALL: rd_mux_s = zext(fall_en_r);
            default: rd_mux_s = 16'h0000;
        endcase
    end

    // Control registers written from the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r     <= OUT_RESET;
            dir_r     <= DIR_RESET;
            ien_r     <= {WIDTH{1'b0}};
            rise_en_r <= {WIDTH{1'b0}};
            fall_en_r <= {WIDTH{1'b0}};
        end else if (wr_sel_s) begin
            case (bus.addr)
                A_OUT:  out_r     <= wdw_s;
                A_DIR:  dir_r     <= wdw_s;
                A_SET:  out_r     <= out_r | wdw_s;
                A_CLR:  out_r     <= out_r & ~wdw_s;
                A_TGL:  out_r     <= out_r ^ wdw_s;
                A_IEN:  ien_r     <= wdw_s;
                A_RISE: rise_en_r <= wdw_s;
                A_FALL: fall_en_r <= wdw_s;
                default: ;
            endcase
        end
    end

    // Synchroniser chain, edge history and priming counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {WIDTH{1'b0}};
            prev_r      <= {WIDTH{1'b0}};
            prime_cnt_r <= 3'd0;
            primed_r    <= 1'b0;
        end else begin
            sync_r[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            prev_r <= in_s;
            if (!primed_r) begin
                if (prime_cnt_r == PRIME_LAST) primed_r <= 1'b1;
                else prime_cnt_r <= prime_cnt_r + 3'd1;
            end
        end
    end

    // Events (set beats clear), interrupt and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_r <= {WIDTH{1'b0}};
            irq_r <= 1'b0;
            rd_r  <= 16'h0000;
        end else begin
            evt_r <= (evt_r & ~evt_clr_s) | evt_set_s;
            irq_r <= |(evt_r & ien_r);
            if (rd_sel_s) rd_r <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed vector table, hand sequences for edge/reset
// corner cases, and randomized traffic against a behavioural model.
module tb_gpio_bank;
    localparam int         S       = 2;
    localparam logic [7:0] OUT_RST = 8'hA5;
    localparam logic [7:0] DIR_RST = 8'h0F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pin = 8'hFF;
    logic [7:0] pin_out, pin_oe;
    logic       irq;
    logic [4:0] pin5 = 5'd0;
    logic [4:0] pin_out5, pin_oe5;
    logic       irq5;

    gpio_bank_if bus ();
    gpio_bank_if bus5 ();

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(S), .OUT_RESET(OUT_RST), .DIR_RESET(DIR_RST)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .pin_in(pin),
        .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq));

    gpio_bank #(.WIDTH(5), .SYNC_STAGES(3)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5.slave), .pin_in(pin5),
        .pin_out(pin_out5), .pin_oe(pin_oe5), .irq(irq5));

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_out, m_dir, m_ien, m_ren, m_fen, m_evt;
    logic [15:0] m_rd;
    logic        m_irq;
    int          m_since;
    logic [7:0]  pq[$];   // pq[k] = pin value sampled k+1 edges ago

    function automatic logic [15:0] m_reg(input logic [3:0] a);
        case (a)
            4'd0, 4'd2, 4'd3, 4'd4: return {8'h00, m_out};
            4'd1: return {8'h00, m_dir};
            4'd5: return {8'h00, pq[S-1]};
            4'd6: return {8'h00, m_evt};
            4'd7: return {8'h00, m_ien};
            4'd8: return {8'h00, m_ren};
            4'd9: return {8'h00, m_fen};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] in_v, pv, set_v, clr_v, d;
        logic       nirq;
        if (reset) begin
            m_out = OUT_RST; m_dir = DIR_RST;
            m_ien = 8'h00; m_ren = 8'h00; m_fen = 8'h00; m_evt = 8'h00;
            m_rd = 16'h0000; m_irq = 1'b0; m_since = 0;
            pq = {};
            for (int i = 0; i <= S; i++) pq.push_back(8'h00);
        end else begin
            in_v  = pq[S-1];
            pv    = pq[S];
            set_v = (m_since > S) ? ((in_v & ~pv & m_ren) | (~in_v & pv & m_fen)) : 8'h00;
            d     = bus.wd[7:0];
            clr_v = (bus.cs && bus.io_wr && bus.addr == 4'd6) ? d : 8'h00;
            nirq  = |(m_evt & m_ien);
            if (bus.cs && bus.io_rd) m_rd = m_reg(bus.addr);
            if (bus.cs && bus.io_wr) begin
                case (bus.addr)
                    4'd0: m_out = d;
                    4'd1: m_dir = d;
                    4'd2: m_out = m_out | d;
                    4'd3: m_out = m_out & ~d;
                    4'd4: m_out = m_out ^ d;
                    4'd7: m_ien = d;
                    4'd8: m_ren = d;
                    4'd9: m_fen = d;
                    default: ;
                endcase
            end
            m_evt = (m_evt & ~clr_v) | set_v;
            m_irq = nirq;
            pq.push_front(pin);
            void'(pq.pop_back());
            if (m_since < 1000) m_since++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pin_out", {8'h00, pin_out}, {8'h00, m_out});
        chk("model_pin_oe", {8'h00, pin_oe}, {8'h00, m_dir});
        chk("model_rd", bus.rd, m_rd);
        chk("model_irq", {15'd0, irq}, {15'd0, m_irq});
    endtask

    task automatic idle();
        bus.cs = 1'b0; bus.io_wr = 1'b0; bus.io_rd = 1'b0; bus.addr = 4'd0; bus.wd = 16'h0000;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.io_wr = 1'b1; bus.io_rd = 1'b0; bus.addr = a; bus.wd = d;
        tick();
        idle();
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [15:0] exp, input string name);
        bus.cs = 1'b1; bus.io_wr = 1'b0; bus.io_rd = 1'b1; bus.addr = a; bus.wd = 16'h0000;
        tick();
        idle();
        chk(name, bus.rd, exp);
    endtask

    typedef struct {
        logic        cs;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vt[22];

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h003C, 16'h00FF, 8'h3C};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h003C, 8'h3C};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 4'd2,  16'h0001, 16'h003C, 8'h3D};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h003D, 8'h3D};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 4'd3,  16'h000C, 16'h003D, 8'h31};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 4'd3,  16'h0000, 16'h0031, 8'h31};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 4'd4,  16'h00FF, 16'h0031, 8'hCE};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h00CE, 8'hCE};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 4'd0,  16'h0077, 16'h00CE, 8'h77};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 4'd4,  16'h0000, 16'h0077, 8'h77};
        vt[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0077, 8'h77};
        vt[11] = '{1'b0, 1'b0, 1'b1, 4'd1,  16'h0000, 16'h0077, 8'h77};
        vt[12] = '{1'b1, 1'b0, 1'b1, 4'd1,  16'h0000, 16'h000F, 8'h77};
        vt[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 16'h000F, 8'h77};
        vt[14] = '{1'b1, 1'b0, 1'b1, 4'd12, 16'h0000, 16'h0000, 8'h77};
        vt[15] = '{1'b1, 1'b1, 1'b0, 4'd12, 16'hFFFF, 16'h0000, 8'h77};
        vt[16] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'hFF12, 16'h0000, 8'h12};
        vt[17] = '{1'b1, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h0012, 8'h12};
        vt[18] = '{1'b1, 1'b1, 1'b0, 4'd1,  16'h00F0, 16'h0012, 8'h12};
        vt[19] = '{1'b1, 1'b0, 1'b1, 4'd1,  16'h0000, 16'h00F0, 8'h12};
        vt[20] = '{1'b1, 1'b1, 1'b1, 4'd15, 16'hABCD, 16'h0000, 8'h12};
        vt[21] = '{1'b1, 1'b0, 1'b1, 4'd5,  16'h0000, 16'h00FF, 8'h12};

        idle();
        bus5.cs = 1'b0; bus5.io_wr = 1'b0; bus5.io_rd = 1'b0; bus5.addr = 4'd0; bus5.wd = 16'h0000;

        // reset with pins held high
        reset = 1'b1; pin = 8'hFF;
        tick(); tick();
        reset = 1'b0;
        chk("rst_pin_oe", {8'h00, pin_oe}, 16'h000F);
        chk("rst_pin_out", {8'h00, pin_out}, 16'h00A5);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        chk("rst_rd", bus.rd, 16'h0000);
        for (int i = 0; i < S + 3; i++) begin
            bus.cs = 1'b1; bus.io_rd = 1'b1; bus.addr = 4'd6;
            tick();
            chk("prime_evt", bus.rd, 16'h0000);
        end
        idle();
        rd_chk(4'd5, 16'h00FF, "in_readback");

        // directed vector table
        for (int i = 0; i < 22; i++) begin
            bus.cs = vt[i].cs; bus.io_wr = vt[i].wr; bus.io_rd = vt[i].rd;
            bus.addr = vt[i].addr; bus.wd = vt[i].wd;
            tick();
            idle();
            chk($sformatf("vec%0d_rd", i), bus.rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_out", i), {8'h00, pin_out}, {8'h00, vt[i].exp_out});
        end

        // edge capture
        pin = 8'h00;
        repeat (S + 2) tick();
        wr(4'd8, 16'h0001); wr(4'd9, 16'h0002); wr(4'd7, 16'h0003);
        pin = 8'h01; tick();
        pin = 8'h00; tick();
        pin = 8'h02; tick();
        pin = 8'h00;
        repeat (S + 2) tick();
        rd_chk(4'd6, 16'h0003, "evt_both");
        chk("irq_set", {15'd0, irq}, 16'h0001);
        wr(4'd7, 16'h0003);
        rd_chk(4'd6, 16'h0003, "ien_write_keeps_evt");
        wr(4'd6, 16'h0001);
        rd_chk(4'd6, 16'h0002, "w1c_bit0");
        wr(4'd6, 16'h0002);
        rd_chk(4'd6, 16'h0000, "w1c_bit1");
        chk("irq_clr", {15'd0, irq}, 16'h0000);

        // W1C in the same cycle as a rise on bit 0: set wins
        pin = 8'h01;
        repeat (S) tick();
        wr(4'd6, 16'h0001);
        rd_chk(4'd6, 16'h0001, "set_beats_clear");
        wr(4'd6, 16'h0001);
        rd_chk(4'd6, 16'h0000, "clear_after_collision");

        // rd holds between selected reads
        rd_chk(4'd1, 16'h00F0, "rd_dir");
        tick(); tick();
        chk("rd_hold", bus.rd, 16'h00F0);

        // narrow instance: bits above WIDTH dropped
        bus5.cs = 1'b1; bus5.io_wr = 1'b1; bus5.addr = 4'd0; bus5.wd = 16'hFFFF;
        tick();
        bus5.io_wr = 1'b0; bus5.io_rd = 1'b1;
        tick();
        bus5.cs = 1'b0; bus5.io_rd = 1'b0;
        chk("w5_rd", bus5.rd, 16'h001F);
        chk("w5_pin_out", {11'd0, pin_out5}, 16'h001F);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            bus.cs = ($urandom_range(0, 3) != 0);
            bus.addr = 4'($urandom_range(0, 11));
            bus.io_wr = 1'($urandom_range(0, 1));
            bus.io_rd = 1'($urandom_range(0, 1));
            bus.wd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        idle();

        // reset coinciding with a SET write; priming restarts
        wr(4'd0, 16'h0000);
        pin = 8'hFF;
        reset = 1'b1;
        bus.cs = 1'b1; bus.io_wr = 1'b1; bus.addr = 4'd2; bus.wd = 16'h00FF;
        tick();
        reset = 1'b0;
        idle();
        chk("rst_set_out", {8'h00, pin_out}, 16'h00A5);
        chk("rst_set_rd", bus.rd, 16'h0000);
        wr(4'd8, 16'h00FF);
        repeat (S + 3) tick();
        rd_chk(4'd6, 16'h0000, "prime_restart_no_evt");
        pin = 8'h00;
        repeat (S + 1) tick();
        pin = 8'hFF;
        repeat (S + 2) tick();
        rd_chk(4'd6, 16'h00FF, "post_prime_rise");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
